// File: rtl/xadc_oversample_scheduler.sv
// xadc_oversample_scheduler
// Round-robin XADC conversion sequencer (event-driven, single-channel mode).
// Each enabled auxiliary channel is selected, settled, started with a convst
// pulse and its eoc sample is folded into a per-channel partial sum. Every
// 2^LOG2_OS samples a rounded result of 12+LOG2_OS/2 bits is presented on a
// valid/ready output stage.
// Optional build macro: XADC_SCHED_TIMEOUT_EN -- adds an eoc watchdog of
// TIMEOUT cycles in WAIT_EOC that sets the sticky timeout_err and skips the
// conversion. Without it timeout_err is tied low and no counter exists.
module xadc_oversample_scheduler #(
  parameter int         NUM_CH  = 4,
  parameter logic [4:0] CH_BASE = 5'h10,
  parameter int         LOG2_OS = 8,
  parameter int         SETTLE  = 4,
  parameter int         TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [11:0]               sample,
  input  logic                      eoc,
  input  logic [4:0]                eoc_channel,
  output logic [4:0]                adc_channel,
  output logic                      convst,
  output logic [12+LOG2_OS/2-1:0]   result,
  output logic [3:0]                result_ch,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic                      busy,
  output logic                      chan_err,
  output logic                      timeout_err
);

  localparam int HALF  = LOG2_OS / 2;
  localparam int ACC_W = 12 + LOG2_OS;
  localparam int RES_W = 12 + HALF;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    CONVST   = 3'd2,
    WAIT_EOC = 3'd3,
    ACCUM    = 3'd4,
    ADVANCE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4:0]         adc_channel_q, adc_channel_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [11:0]        smp_q, smp_d;
  logic [4:0]         eoc_ch_q, eoc_ch_d;
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic [LOG2_OS-1:0] cnt_q [NUM_CH];
  logic [LOG2_OS-1:0] cnt_d [NUM_CH];
  logic [RES_W-1:0]   result_q, result_d;
  logic [3:0]         result_ch_q, result_ch_d;
  logic               result_valid_q, result_valid_d;
  logic               chan_err_q, chan_err_d;
  logic [ACC_W-1:0]   sum;

`ifdef XADC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
`else
  logic            unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Round-half-up of the full partial sum down to the result width.
  function automatic logic [RES_W-1:0] round_result(input logic [ACC_W-1:0] s);
    logic [ACC_W-1:0] r;
    r = s + ACC_W'(1 << (HALF - 1));
    return r[ACC_W-1:HALF];
  endfunction

  // First enabled index at or after (from + first_off), wrapping; keeps
  // 'from' if nothing is enabled (callers guard on a non-zero mask).
  function automatic logic [IDX_W-1:0] pick_idx(input logic [IDX_W-1:0] from,
                                                input logic [NUM_CH-1:0] mask,
                                                input int first_off);
    logic [IDX_W-1:0]  sel;
    logic              found;
    logic [NUM_CH-1:0] sh;
    int                c;
    sel   = from;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(from) + first_off + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      sh = mask >> c;
      if (!found && sh[0]) begin
        sel   = IDX_W'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Sequencer next-state, shared accumulate/round datapath and output stage.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    adc_channel_d  = adc_channel_q;
    settle_d       = settle_q;
    smp_d          = smp_q;
    eoc_ch_d       = eoc_ch_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_ch_d    = result_ch_q;
    result_valid_d = result_valid_q;
    chan_err_d     = chan_err_q;
    sum            = acc_q[idx_q] + ACC_W'(smp_q);
`ifdef XADC_SCHED_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    timeout_err_d  = timeout_err_q;
`endif

    // A transfer empties the stage unless a new result loads below.
    if (result_valid_q && result_ready) result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) begin
          idx_d         = pick_idx(idx_q, ch_mask, 0);
          adc_channel_d = CH_BASE + 5'(idx_d);
          settle_d      = '0;
          state_d       = SELECT;
        end
      end
      SELECT: begin
        if (settle_q == SET_W'(SETTLE - 1)) state_d = CONVST;
        else                                settle_d = settle_q + 1'b1;
      end
      CONVST: begin
        state_d = WAIT_EOC;
`ifdef XADC_SCHED_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT_EOC: begin
        if (eoc) begin
          smp_d    = sample;
          eoc_ch_d = eoc_channel;
          state_d  = ACCUM;
        end
`ifdef XADC_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ADVANCE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ACCUM: begin
        if (eoc_ch_q != adc_channel_q) begin
          // Wrong channel converted: drop the sample, keep the count.
          chan_err_d = 1'b1;
          state_d    = ADVANCE;
        end else if (&cnt_q[idx_q]) begin
          // Final sample of the block; hold here while the stage is full.
          if (!(result_valid_q && !result_ready)) begin
            result_d       = round_result(sum);
            result_ch_d    = 4'(idx_q);
            result_valid_d = 1'b1;
            acc_d[idx_q]   = '0;
            cnt_d[idx_q]   = '0;
            state_d        = ADVANCE;
          end
        end else begin
          acc_d[idx_q] = sum;
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
          state_d      = ADVANCE;
        end
      end
      ADVANCE: begin
        if (!enable || (ch_mask == '0)) begin
          state_d = IDLE;
        end else begin
          idx_d         = pick_idx(idx_q, ch_mask, 1);
          adc_channel_d = CH_BASE + 5'(idx_d);
          settle_d      = '0;
          state_d       = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, per-channel partial sums and output stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      adc_channel_q  <= CH_BASE;
      settle_q       <= '0;
      smp_q          <= '0;
      eoc_ch_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      chan_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      adc_channel_q  <= adc_channel_d;
      settle_q       <= settle_d;
      smp_q          <= smp_d;
      eoc_ch_q       <= eoc_ch_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_ch_q    <= result_ch_d;
      result_valid_q <= result_valid_d;
      chan_err_q     <= chan_err_d;
    end
  end

`ifdef XADC_SCHED_TIMEOUT_EN
  // eoc watchdog counter and its sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign adc_channel  = adc_channel_q;
  assign convst       = (state_q == CONVST);
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != IDLE);
  assign chan_err     = chan_err_q;

endmodule
